vga_timing_gen: RTL and testbench

- Raster timing source for the display path; directly upstream of the frame buffer controller.
- Generates `counter_H` / `counter_V` for 640x480@60 (25 MHz pixel rate).
- Produces `hsync`, `vsync` and blanking, delayed to line up with the controller's registered `colour` output.
- Gates the returned `colour` to the VGA pin and issues per-frame ticks for game logic to update entity registers during vblank.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/sync_delay_line.sv | 43 ++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, counter width and helpers for the VGA timing generator.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
   localparam logic [CNT_W-1:0] H_FP     = 10'd16;
   localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
   localparam logic [CNT_W-1:0] H_BP     = 10'd48;
   localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
   localparam logic [CNT_W-1:0] V_FP     = 10'd10;
   localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
   localparam logic [CNT_W-1:0] V_BP     = 10'd33;

   function automatic logic [CNT_W-1:0] timing_total(input logic [CNT_W-1:0] active,
                                                     input logic [CNT_W-1:0] fp,
                                                     input logic [CNT_W-1:0] sync,
                                                     input logic [CNT_W-1:0] bp);
      return active + fp + sync + bp;
   endfunction

   function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (pos >= lo) && (pos <= hi);
   endfunction

   localparam logic [CNT_W-1:0] H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam logic [CNT_W-1:0] V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [CNT_W-1:0] HS_START = H_ACTIVE + H_FP;
   localparam logic [CNT_W-1:0] HS_END   = HS_START + H_SYNC - 10'd1;
   localparam logic [CNT_W-1:0] VS_START = V_ACTIVE + V_FP;
   localparam logic [CNT_W-1:0] VS_END   = VS_START + V_SYNC - 10'd1;

   // Raw (undelayed) raster terms, always asserted-high internally.
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } raw_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Display-side signal bundle of the VGA timing generator; master = generator, slave = consumer.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic             colour;
   logic [CNT_W-1:0] counter_H;
   logic [CNT_W-1:0] counter_V;
   logic             hsync;
   logic             vsync;
   logic             display_on;
   logic             vga_pixel;
   logic             frame_tick;
   logic [7:0]       frame_count;

   modport master (
      input  colour,
      output counter_H, counter_V, hsync, vsync, display_on, vga_pixel, frame_tick, frame_count
   );

   modport slave (
      output colour,
      input  counter_H, counter_V, hsync, vsync, display_on, vga_pixel, frame_tick, frame_count
   );

endinterface

// File: rtl/sync_delay_line.sv
// Enabled WIDTH x DEPTH shift register; every stage loads rst_val on asynchronous active-low reset.
module sync_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i];
      end
      if (en) begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= rst_val;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source with delayed sync/blanking and per-frame tick.
// Optional VGA_CLK_DIV2_EN: clk runs at twice the pixel rate and a toggle flop strobes every other cycle.
module vga_timing_gen #(
   parameter logic [vga_timing_pkg::CNT_W-1:0] H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
   parameter logic [vga_timing_pkg::CNT_W-1:0] H_FP       = vga_timing_pkg::H_FP,
   parameter logic [vga_timing_pkg::CNT_W-1:0] H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter logic [vga_timing_pkg::CNT_W-1:0] H_BP       = vga_timing_pkg::H_BP,
   parameter logic [vga_timing_pkg::CNT_W-1:0] V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
   parameter logic [vga_timing_pkg::CNT_W-1:0] V_FP       = vga_timing_pkg::V_FP,
   parameter logic [vga_timing_pkg::CNT_W-1:0] V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter logic [vga_timing_pkg::CNT_W-1:0] V_BP       = vga_timing_pkg::V_BP,
   parameter bit                               SYNC_POL   = 1'b0,
   parameter int                               PIPE_DELAY = 3
) (
   input  logic              clk,
   input  logic              reset,
   vga_timing_gen_if.master  vga
);
   import vga_timing_pkg::*;

   localparam logic [CNT_W-1:0] H_MAX  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 10'd1;
   localparam logic [CNT_W-1:0] V_MAX  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 10'd1;
   localparam logic [CNT_W-1:0] HS_LO  = H_ACTIVE + H_FP;
   localparam logic [CNT_W-1:0] HS_HI  = H_ACTIVE + H_FP + H_SYNC - 10'd1;
   localparam logic [CNT_W-1:0] VS_LO  = V_ACTIVE + V_FP;
   localparam logic [CNT_W-1:0] VS_HI  = V_ACTIVE + V_FP + V_SYNC - 10'd1;
   localparam logic [CNT_W-1:0] V_TICK = V_ACTIVE - 10'd1;
   // Out-of-range delays are clamped to the supported 1..7 stages.
   localparam int DEPTH = (PIPE_DELAY < 1) ? 1 : ((PIPE_DELAY > 7) ? 7 : PIPE_DELAY);

   logic pix_en;

`ifdef VGA_CLK_DIV2_EN
   logic toggle_q, toggle_d;

   always_comb begin
      toggle_d = ~toggle_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         toggle_q <= 1'b0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign pix_en = toggle_q;
`else
   assign pix_en = 1'b1;
`endif

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic             frame_tick_q, frame_tick_d;
   logic [7:0]       frame_count_q, frame_count_d;
   logic             h_wrap, v_wrap;

   always_comb begin
      h_wrap        = (h_q == H_MAX);
      v_wrap        = (v_q == V_MAX);
      h_d           = h_q;
      v_d           = v_q;
      frame_tick_d  = 1'b0;
      frame_count_d = frame_count_q;
      if (pix_en) begin
         h_d = h_wrap ? '0 : h_q + 10'd1;
         if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 10'd1;
         end
         // Last pixel of the last visible line: vblank starts on the next strobe.
         if (h_wrap && (v_q == V_TICK)) begin
            frame_tick_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_q           <= '0;
         v_q           <= '0;
         frame_tick_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         frame_tick_q  <= frame_tick_d;
         frame_count_q <= frame_count_d;
      end
   end

   raw_t raw_now, raw_dly;

   always_comb begin
      raw_now.hs = in_window(h_q, HS_LO, HS_HI);
      raw_now.vs = in_window(v_q, VS_LO, VS_HI);
      raw_now.de = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
   end

   // Resetting the stages to the deasserted terms keeps sync glitch-free across a mid-frame reset.
   sync_delay_line #(
      .WIDTH ($bits(raw_t)),
      .DEPTH (DEPTH)
   ) u_sync_delay_line (
      .clk     (clk),
      .rst_n   (reset),
      .en      (pix_en),
      .rst_val ('0),
      .din     (raw_now),
      .dout    (raw_dly)
   );

   assign vga.counter_H   = h_q;
   assign vga.counter_V   = v_q;
   assign vga.hsync       = raw_dly.hs ? SYNC_POL : ~SYNC_POL;
   assign vga.vsync       = raw_dly.vs ? SYNC_POL : ~SYNC_POL;
   assign vga.display_on  = raw_dly.de;
   assign vga.vga_pixel   = vga.colour & raw_dly.de;
   assign vga.frame_tick  = frame_tick_q;
   assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 instance plus a shrunken-raster instance for frame-level behaviour.
module tb_vga_timing_gen;

`ifdef VGA_CLK_DIV2_EN
   localparam int K = 2;
`else
   localparam int K = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic colour = 1'b1;
   int   e_cnt = 0;
   int   n_checks = 0;
   int   n_err = 0;

   always #10 clk = ~clk;

   vga_timing_gen_if if_a ();
   vga_timing_gen_if if_b ();

   vga_timing_gen u_dut_a (
      .clk   (clk),
      .reset (rst_n),
      .vga   (if_a)
   );

   vga_timing_gen #(
      .H_ACTIVE (10'd8), .H_FP (10'd2), .H_SYNC (10'd3), .H_BP (10'd2),
      .V_ACTIVE (10'd4), .V_FP (10'd1), .V_SYNC (10'd2), .V_BP (10'd2),
      .SYNC_POL (1'b1),  .PIPE_DELAY (5)
   ) u_dut_b (
      .clk   (clk),
      .reset (rst_n),
      .vga   (if_b)
   );

   // Clock edges seen since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) e_cnt = 0;
      else        e_cnt = e_cnt + 1;
   end

   function automatic logic [32:0] model(input int e, input int ha, input int hf, input int hsw,
                                         input int hb, input int va, input int vf, input int vsw,
                                         input int vb, input int d, input bit pol, input bit col);
      int ht, vt, s, ft, idx, hp, vp, fc;
      bit hs, vs, de, tick, strobe_edge;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
`ifdef VGA_CLK_DIV2_EN
      s = e / 2;
      strobe_edge = (e > 0) && (e % 2 == 0);
`else
      s = e;
      strobe_edge = (e > 0);
`endif
      ft  = ht * vt;
      idx = va * ht - 1;
      hs = 1'b0; vs = 1'b0; de = 1'b0;
      if (s >= d) begin
         hp = (s - d) % ht;
         vp = ((s - d) / ht) % vt;
         hs = (hp >= ha + hf) && (hp < ha + hf + hsw);
         vs = (vp >= va + vf) && (vp < va + vf + vsw);
         de = (hp < ha) && (vp < va);
      end
      tick = strobe_edge && (s >= 1) && (((s - 1) % ft) == idx);
      fc = ((s + ft - idx - 1) / ft) % 256;
      return {10'(s % ht), 10'((s / ht) % vt), (hs ? pol : !pol), (vs ? pol : !pol),
              de, de & col, tick, 8'(fc)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e_cnt);
      end
   endtask

   task automatic wait_e(input int n);
      int guard;
      guard = 0;
      while (e_cnt != n && guard < 100000) begin
         @(negedge clk);
         guard++;
      end
      chk("wait_edge_count", 64'(e_cnt), 64'(n));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         colour = (e_cnt < 2000) ? 1'b1 : (e_cnt[0] ^ e_cnt[3]);
      end
   end

   assign if_a.colour = colour;
   assign if_b.colour = colour;

   initial begin
      forever begin
         @(negedge clk);
         chk("dut_a_cycle",
             64'({if_a.counter_H, if_a.counter_V, if_a.hsync, if_a.vsync, if_a.display_on,
                  if_a.vga_pixel, if_a.frame_tick, if_a.frame_count}),
             64'(model(e_cnt, 640, 16, 96, 48, 480, 10, 2, 33, 3, 1'b0, colour)));
         chk("dut_b_cycle",
             64'({if_b.counter_H, if_b.counter_V, if_b.hsync, if_b.vsync, if_b.display_on,
                  if_b.vga_pixel, if_b.frame_tick, if_b.frame_count}),
             64'(model(e_cnt, 8, 2, 3, 2, 4, 1, 2, 2, 5, 1'b1, colour)));
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_a_counter_H", 64'(if_a.counter_H), 64'd0);
      chk("rst_a_hsync", 64'(if_a.hsync), 64'd1);
      chk("rst_a_vsync", 64'(if_a.vsync), 64'd1);
      chk("rst_a_display_on", 64'(if_a.display_on), 64'd0);
      chk("rst_a_vga_pixel", 64'(if_a.vga_pixel), 64'd0);
      chk("rst_b_hsync_pol1", 64'(if_b.hsync), 64'd0);
      chk("rst_b_frame_count", 64'(if_b.frame_count), 64'd0);
      #2 rst_n = 1'b1;

      wait_e(K * 2);   chk("a_de_s2", 64'(if_a.display_on), 64'd0);
      wait_e(K * 3);   chk("a_de_s3", 64'(if_a.display_on), 64'd1);
                       chk("a_pix_s3", 64'(if_a.vga_pixel), 64'd1);
      wait_e(K * 60);  chk("b_tick_s60", 64'(if_b.frame_tick), 64'd1);
                       chk("b_fc_s60", 64'(if_b.frame_count), 64'd1);
      wait_e(K * 61);  chk("b_tick_s61", 64'(if_b.frame_tick), 64'd0);
      wait_e(K * 79);  chk("b_vsync_s79", 64'(if_b.vsync), 64'd0);
      wait_e(K * 80);  chk("b_vsync_s80", 64'(if_b.vsync), 64'd1);
      wait_e(K * 642); chk("a_de_s642", 64'(if_a.display_on), 64'd1);
      wait_e(K * 643); chk("a_de_s643", 64'(if_a.display_on), 64'd0);
                       chk("a_pix_s643", 64'(if_a.vga_pixel), 64'd0);
      wait_e(K * 658); chk("a_hsync_s658", 64'(if_a.hsync), 64'd1);
      wait_e(K * 659); chk("a_hsync_s659", 64'(if_a.hsync), 64'd0);
                       chk("a_counter_H_s659", 64'(if_a.counter_H), 64'd659);
      wait_e(K * 754); chk("a_hsync_s754", 64'(if_a.hsync), 64'd0);
      wait_e(K * 755); chk("a_hsync_s755", 64'(if_a.hsync), 64'd1);
      wait_e(K * 799); chk("a_counter_H_s799", 64'(if_a.counter_H), 64'd799);
                       chk("a_counter_V_s799", 64'(if_a.counter_V), 64'd0);
      wait_e(K * 800); chk("a_counter_H_s800", 64'(if_a.counter_H), 64'd0);
                       chk("a_counter_V_s800", 64'(if_a.counter_V), 64'd1);
      wait_e(K * 34484); chk("b_fc_255", 64'(if_b.frame_count), 64'd255);
      wait_e(K * 34485); chk("b_fc_wrap", 64'(if_b.frame_count), 64'd0);
                         chk("b_tick_wrap", 64'(if_b.frame_tick), 64'd1);

      wait_e(K * 34600);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_a_counter_H", 64'(if_a.counter_H), 64'd0);
      chk("mid_rst_a_counter_V", 64'(if_a.counter_V), 64'd0);
      chk("mid_rst_a_hsync", 64'(if_a.hsync), 64'd1);
      chk("mid_rst_a_display_on", 64'(if_a.display_on), 64'd0);
      chk("mid_rst_a_vga_pixel", 64'(if_a.vga_pixel), 64'd0);
      chk("mid_rst_b_frame_count", 64'(if_b.frame_count), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      wait_e(K * 658); chk("post_rst_a_hsync_s658", 64'(if_a.hsync), 64'd1);
      wait_e(K * 659); chk("post_rst_a_hsync_s659", 64'(if_a.hsync), 64'd0);
      wait_e(K * 1000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
